arb4_rr_mux: RTL

- Round-robin arbiter and sequencer that shares one 1-bit 4:1 multiplexer between four requesters.
- Each requester raises `req[i]`. The block grants one requester at a time and drives the mux select from the registered grant.
- The selected data bit is presented on `out`.
- Sits in front of the ALU operand-select path. A grant is held while its request stays high, with forced rotation after `MAX_HOLD` cycles when others are waiting.

---
 rtl/arb_pkg.sv | 18 +
 rtl/mux4_1.sv | 26 ++
 rtl/rr_pick4.sv | 28 ++
 rtl/arb4_rr_mux.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  arb_pkg : shared constants and state encoding for the 4-way RR arbiter
//  Revision: 1.0
// ============================================================================
package arb_pkg;

    localparam int NREQ             = 4;
    localparam int SELW             = 2;
    localparam int DEFAULT_MAX_HOLD = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/mux4_1.sv
`default_nettype none
// ============================================================================
//  mux4_1 : 1-bit 4:1 multiplexer shared by the operand-select path
//  Revision: 1.0
// ============================================================================
module mux4_1 (
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic [1:0] S,
    output logic       Y
);

    always_comb begin
        Y = 1'b0;
        case (S)
            2'd0:    Y = a;
            2'd1:    Y = b;
            2'd2:    Y = c;
            default: Y = d;
        endcase
    end

endmodule : mux4_1
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
//  rr_pick4 : first set bit of cand, searching ptr, ptr+1, ptr+2, ptr+3 mod 4
//  Revision: 1.0
// ============================================================================
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] cand,
    input  logic [SELW-1:0] ptr,
    output logic            any,
    output logic [SELW-1:0] idx
);

    // Walk from the farthest offset back to ptr so the nearest hit wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand[ptr + SELW'(k)]) begin
                any = 1'b1;
                idx = ptr + SELW'(k);
            end
        end
    end

endmodule : rr_pick4
`default_nettype wire

// File: rtl/arb4_rr_mux.sv
`default_nettype none
// ============================================================================
//  arb4_rr_mux : round-robin arbiter with bounded hold driving a shared 4:1 mux
//  Revision: 1.0
// ============================================================================
module arb4_rr_mux
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
    parameter int CW       = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] d,
    output logic [NREQ-1:0] gnt,
    output logic [SELW-1:0] sel,
    output logic            valid,
    output logic            out
);

    localparam logic [CW-1:0] c_max_hold = CW'(MAX_HOLD);
    localparam logic [CW-1:0] c_one      = CW'(1);

    state_t          r_state;
    logic [NREQ-1:0] r_gnt;
    logic [SELW-1:0] r_sel;
    logic            r_valid;
    logic [SELW-1:0] r_ptr;
    logic [CW-1:0]   r_hold_cnt;

    state_t          w_state_nxt;
    logic [NREQ-1:0] w_gnt_nxt;
    logic [SELW-1:0] w_sel_nxt;
    logic            w_valid_nxt;
    logic [SELW-1:0] w_ptr_nxt;
    logic [CW-1:0]   w_hold_nxt;

    logic [NREQ-1:0] w_others;
    logic [NREQ-1:0] w_cand;
    logic            w_owner_req;
    logic            w_at_max;
    logic            w_pick_any;
    logic [SELW-1:0] w_pick_idx;
    logic            w_take;
    logic            w_mux_y;

    // In GRANT the owner is masked out; on release its bit is already low,
    // so the same masked vector serves both release and forced rotation.
    assign w_others    = req & ~r_gnt;
    assign w_cand      = (r_state == GRANT) ? w_others : req;
    assign w_owner_req = req[r_sel];
    assign w_at_max    = (r_hold_cnt >= c_max_hold);

    rr_pick4 u_pick (
        .cand (w_cand),
        .ptr  (r_ptr),
        .any  (w_pick_any),
        .idx  (w_pick_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_valid_nxt = r_valid;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold_cnt;
        w_take      = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_take = 1'b1;
                end
            end
            GRANT: begin
                if (!w_owner_req) begin
                    if (w_pick_any) begin
                        w_take = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                        w_sel_nxt   = '0;
                        w_valid_nxt = 1'b0;
                        w_hold_nxt  = '0;
                    end
                end else if (w_at_max) begin
                    // Saturated hold: rotate as soon as anyone else shows up.
                    if (w_pick_any) begin
                        w_take = 1'b1;
                    end
                end else begin
                    w_hold_nxt = r_hold_cnt + c_one;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_sel_nxt   = '0;
                w_valid_nxt = 1'b0;
                w_hold_nxt  = '0;
            end
        endcase

        if (w_take) begin
            w_state_nxt = GRANT;
            w_gnt_nxt   = NREQ'(1) << w_pick_idx;
            w_sel_nxt   = w_pick_idx;
            w_valid_nxt = 1'b1;
            w_hold_nxt  = c_one;
            w_ptr_nxt   = w_pick_idx + SELW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_sel      <= '0;
            r_valid    <= 1'b0;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_sel      <= w_sel_nxt;
            r_valid    <= w_valid_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    mux4_1 u_mux (
        .a (d[0]),
        .b (d[1]),
        .c (d[2]),
        .d (d[3]),
        .S (r_sel),
        .Y (w_mux_y)
    );

    assign gnt   = r_gnt;
    assign sel   = r_sel;
    assign valid = r_valid;
    assign out   = w_mux_y & r_valid;

endmodule : arb4_rr_mux
`default_nettype wire
